// File: rtl/npu_pkg.sv
// Shared NPU definitions: scratchpad geometry and host transfer engine encodings.
// The tile processor imports the same SRAM widths so both ends agree on the scratchpad shape.
package npu_pkg;
    localparam int SRAM_ADDR_W = 10;
    localparam int SRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        OP_WRITE_A = 2'd0,
        OP_WRITE_B = 2'd1,
        OP_READ_C  = 2'd2,
        OP_RSVD    = 2'd3
    } xfer_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } xfer_state_t;
endpackage

// File: rtl/npu_skid_fifo.sv
// Small valid/ready FIFO for the SRAM C read return path.
// The head entry stays stable until it is popped; a push and a pop in the same cycle leave the count unchanged.
module npu_skid_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o
);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              do_push, do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push_i && ((cnt_q != CNT_FULL) || do_pop);

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/npu_host_xfer.sv
// Host-side transfer engine: streams bytes into SRAM A/B and returns SRAM C bytes on a
// backpressured outbound stream. It only drives the SRAM ports while the tile processor is idle.
module npu_host_xfer
    import npu_pkg::*;
#(
    parameter int ADDR_W     = SRAM_ADDR_W,
    parameter int DATA_W     = SRAM_DATA_W,
    parameter int OBUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_len_m1,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              sram_A_we,
    output logic [ADDR_W-1:0] sram_A_addr,
    output logic [DATA_W-1:0] sram_A_din,
    output logic              sram_B_we,
    output logic [ADDR_W-1:0] sram_B_addr,
    output logic [DATA_W-1:0] sram_B_din,
    output logic [ADDR_W-1:0] sram_C_addr,
    input  logic [DATA_W-1:0] sram_C_dout,
    output logic              busy,
    output logic              xfer_done
);
    localparam int CNT_W = $clog2(OBUF_DEPTH + 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    xfer_state_t       state_q;
    xfer_op_t          op_q;
    xfer_op_t          cmd_op_t;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   rem_q;      // one bit wider so a 1024-byte transfer fits
    logic              inflight_q;
    logic              done_q;

    logic              wr_beat, sel_a, sel_b;
    logic              rd_issue, credit_ok, fifo_pop, fifo_empty, drain_done;
    logic [CNT_W-1:0]  fifo_cnt;

    assign cmd_op_t  = xfer_op_t'(cmd_op);
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign xfer_done = done_q;

    assign wr_ready = (state_q == ST_WRITE);
    assign wr_beat  = wr_ready && wr_valid;
    assign sel_a    = wr_ready && (op_q == OP_WRITE_A);
    assign sel_b    = wr_ready && (op_q == OP_WRITE_B);

    assign sram_A_we   = sel_a && wr_valid;
    assign sram_A_addr = sel_a ? addr_q : '0;
    assign sram_A_din  = sel_a ? wr_data : '0;
    assign sram_B_we   = sel_b && wr_valid;
    assign sram_B_addr = sel_b ? addr_q : '0;
    assign sram_B_din  = sel_b ? wr_data : '0;

    // Credit counts the slot freed by this cycle's pop so one byte per cycle is sustained.
    assign fifo_pop   = rd_valid && rd_ready;
    assign credit_ok  = (int'(fifo_cnt) + int'(inflight_q) - int'(fifo_pop)) < OBUF_DEPTH;
    assign rd_issue   = (state_q == ST_READ) && (rem_q != '0) && credit_ok;
    assign sram_C_addr = rd_issue ? addr_q : '0;
    assign drain_done = !inflight_q && ((fifo_cnt == '0) || ((fifo_cnt == CNT_ONE) && fifo_pop));

    npu_skid_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (OBUF_DEPTH)
    ) u_obuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .data_i  (sram_C_dout),
        .pop_i   (fifo_pop),
        .data_o  (rd_data),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty)
    );
    assign rd_valid = !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_WRITE_A;
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= rd_issue;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_op_t;
                        addr_q <= cmd_base;
                        rem_q  <= {1'b0, cmd_len_m1} + REM_ONE;
                        case (cmd_op_t)
                            OP_WRITE_A, OP_WRITE_B: state_q <= ST_WRITE;
                            OP_READ_C:              state_q <= ST_READ;
                            default:                done_q  <= 1'b1;
                        endcase
                    end
                end
                ST_WRITE: begin
                    if (wr_beat) begin
                        addr_q <= addr_q + ADDR_ONE;
                        rem_q  <= rem_q - REM_ONE;
                        if (rem_q == REM_ONE) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (rd_issue) begin
                        addr_q <= addr_q + ADDR_ONE;
                        rem_q  <= rem_q - REM_ONE;
                        if (rem_q == REM_ONE) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_npu_host_xfer.sv
// Directed bench for npu_host_xfer with behavioural SRAMs and write/read logs.
module tb_npu_host_xfer;
    import npu_pkg::*;
    localparam int AW = 10;
    localparam int DW = 8;

    typedef logic [7:0] byte_q_t[$];
    typedef struct { int a; int d; int c; } wr_ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_base, cmd_len_m1;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready;
    logic [DW-1:0] rd_data;
    logic          sram_A_we, sram_B_we;
    logic [AW-1:0] sram_A_addr, sram_B_addr, sram_C_addr;
    logic [DW-1:0] sram_A_din, sram_B_din;
    logic [DW-1:0] sram_C_dout = '0;
    logic          busy, xfer_done;

    logic [DW-1:0] memA [1024];
    logic [DW-1:0] memC [1024];
    wr_ent_t       a_log[$], b_log[$];
    int            rd_log[$], rd_cyc[$];
    int            cyc = 0, acc_cyc = 0, done_n = 0, done_cyc = 0, sel_err = 0;
    int            n_cmp = 0, n_bad = 0;
    logic          stall_q = 1'b0;
    logic [DW-1:0] stall_d = '0;

    always #5 clk = ~clk;

    npu_host_xfer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_len_m1(cmd_len_m1),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .sram_A_we(sram_A_we), .sram_A_addr(sram_A_addr), .sram_A_din(sram_A_din),
        .sram_B_we(sram_B_we), .sram_B_addr(sram_B_addr), .sram_B_din(sram_B_din),
        .sram_C_addr(sram_C_addr), .sram_C_dout(sram_C_dout),
        .busy(busy), .xfer_done(xfer_done)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // SRAM models: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sram_A_we) memA[sram_A_addr] <= sram_A_din;
        sram_C_dout <= memC[sram_C_addr];
    end

    // Mid-cycle observation of every handshake.
    always @(negedge clk) begin
        if (sram_A_we) a_log.push_back('{a: int'(sram_A_addr), d: int'(sram_A_din), c: cyc});
        if (sram_B_we) b_log.push_back('{a: int'(sram_B_addr), d: int'(sram_B_din), c: cyc});
        if (sram_A_we && (sram_B_we || sram_B_addr != '0)) sel_err++;
        if (sram_B_we && (sram_A_we || sram_A_addr != '0)) sel_err++;
        if (rd_valid && rd_ready) begin
            rd_log.push_back(int'(rd_data));
            rd_cyc.push_back(cyc);
        end
        if (xfer_done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (rst_n && stall_q) begin
            chk("hold_valid", rd_valid, 1);
            chk("hold_data", rd_data, stall_d);
        end
        stall_q = rst_n && rd_valid && !rd_ready;
        stall_d = rd_data;
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_cmd(input logic [1:0] op, input int base, input int lm1);
        int g = 0;
        cmd_op = op; cmd_base = AW'(base); cmd_len_m1 = AW'(lm1); cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && g < 3000) begin @(negedge clk); g++; end
        if (g >= 3000) chk("cmd_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic push_bytes(input byte_q_t b);
        int k = 0, g = 0;
        wr_valid = 1'b1; wr_data = b[0];
        while (k < b.size() && g < b.size() + 20) begin
            @(negedge clk); g++;
            if (wr_ready) k++;
            @(posedge clk); #1;
            if (k < b.size()) wr_data = b[k];
        end
        wr_valid = 1'b0;
        if (k != b.size()) chk("wr_timeout", k, b.size());
    endtask

    task automatic wait_done(input int lim);
        int st = done_n, i = 0;
        while (done_n == st && i < lim) begin @(negedge clk); #1; i++; end
        if (done_n == st) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        byte_q_t q;
        int a0, b0, r0, d0, c;
        int pat[4] = '{1, 0, 0, 1};
        cmd_valid = 0; cmd_op = 0; cmd_base = 0; cmd_len_m1 = 0;
        wr_valid = 0; wr_data = 0; rd_ready = 0;
        for (int i = 0; i < 1024; i++) begin memA[i] = '0; memC[i] = '0; end
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_we", {sram_A_we, sram_B_we}, 0);
        chk("rst_addr", {sram_A_addr, sram_B_addr, sram_C_addr}, 0);
        chk("rst_done", xfer_done, 0);
        rst_n = 1'b1;
        idle(1);

        // WRITE_A base 5, four bytes, no bubbles
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        a0 = a_log.size(); d0 = done_n;
        send_cmd(OP_WRITE_A, 5, 3);
        push_bytes(q);
        chk("wa_done", xfer_done, 1);
        chk("wa_busy", busy, 0);
        chk("wa_nwr", a_log.size() - a0, 4);
        for (int k = 0; k < 4; k++) begin
            chk("wa_addr", a_log[a0+k].a, 5 + k);
            chk("wa_data", a_log[a0+k].d, q[k]);
            chk("wa_cyc", a_log[a0+k].c, acc_cyc + k);
        end
        idle(3);
        chk("wa_npulse", done_n - d0, 1);
        chk("wa_no_b", b_log.size(), 0);

        // WRITE_B wrapping past the top address
        q = '{8'h51, 8'h52, 8'h53, 8'h54};
        b0 = b_log.size(); a0 = a_log.size();
        send_cmd(OP_WRITE_B, 1022, 3);
        push_bytes(q);
        chk("wb_busy", busy, 0);
        chk("wb_done", xfer_done, 1);
        chk("wb_nwr", b_log.size() - b0, 4);
        chk("wb_addr0", b_log[b0].a, 1022);
        chk("wb_addr1", b_log[b0+1].a, 1023);
        chk("wb_addr2", b_log[b0+2].a, 0);
        chk("wb_addr3", b_log[b0+3].a, 1);
        chk("wb_data3", b_log[b0+3].d, 8'h54);
        chk("wb_no_a", a_log.size() - a0, 0);
        idle(2);

        // Reserved op: accepted, immediate done, no SRAM traffic
        a0 = a_log.size(); b0 = b_log.size(); r0 = rd_log.size();
        send_cmd(OP_RSVD, 7, 5);
        chk("rsvd_done", xfer_done, 1);
        chk("rsvd_busy", busy, 0);
        idle(3);
        chk("rsvd_quiet", (a_log.size() - a0) + (b_log.size() - b0) + (rd_log.size() - r0), 0);
        chk("rsvd_done_low", xfer_done, 0);

        // READ_C 8 bytes at full rate
        for (int i = 0; i < 8; i++) memC[i] = 8'hA0 + 8'(i);
        rd_ready = 1'b1;
        r0 = rd_log.size();
        send_cmd(OP_READ_C, 0, 7);
        wait_done(40);
        chk("rc_latency", done_cyc - acc_cyc, 10);
        chk("rc_nrd", rd_log.size() - r0, 8);
        for (int k = 0; k < 8; k++) begin
            chk("rc_data", rd_log[r0+k], 8'hA0 + k);
            chk("rc_cyc", rd_cyc[r0+k], acc_cyc + 2 + k);
        end
        idle(2);

        // READ_C 16 bytes with rd_ready toggling 1,0,0,1
        for (int i = 0; i < 16; i++) memC[100+i] = 8'h30 + 8'(3*i);
        r0 = rd_log.size(); d0 = done_n; c = 0;
        send_cmd(OP_READ_C, 100, 15);
        while (done_n == d0 && c < 300) begin
            rd_ready = (pat[c%4] != 0);
            @(negedge clk); #1;
            c++;
            @(posedge clk); #1;
        end
        rd_ready = 1'b1;
        chk("rs_finished", done_n - d0, 1);
        chk("rs_nrd", rd_log.size() - r0, 16);
        for (int k = 0; k < 16; k++) chk("rs_data", rd_log[r0+k], 8'h30 + 3*k);
        idle(2);

        // Back-to-back WRITE_A then a held READ_C of the same bytes
        q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        r0 = rd_log.size();
        send_cmd(OP_WRITE_A, 200, 3);
        cmd_op = OP_READ_C; cmd_base = AW'(200); cmd_len_m1 = AW'(3); cmd_valid = 1'b1;
        chk("bb_not_ready", cmd_ready, 0);
        push_bytes(q);
        for (int k = 0; k < 4; k++) memC[200+k] = memA[200+k];
        chk("bb_done", xfer_done, 1);
        chk("bb_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("bb_started", busy, 1);
        wait_done(40);
        chk("bb_nrd", rd_log.size() - r0, 4);
        for (int k = 0; k < 4; k++) chk("bb_data", rd_log[r0+k], q[k]);
        idle(2);

        // Reset pulsed after 3 of 8 bytes
        for (int i = 0; i < 8; i++) memC[300+i] = 8'h60 + 8'(i);
        r0 = rd_log.size(); c = 0;
        send_cmd(OP_READ_C, 300, 7);
        while (rd_log.size() - r0 < 3 && c < 40) begin @(negedge clk); #1; c++; end
        rst_n = 1'b0;
        #1;
        chk("rr_rd_valid", rd_valid, 0);
        chk("rr_cmd_ready", cmd_ready, 1);
        chk("rr_busy", busy, 0);
        chk("rr_we", {sram_A_we, sram_B_we}, 0);
        a0 = a_log.size(); b0 = b_log.size();
        idle(2);
        rst_n = 1'b1;
        idle(3);
        chk("rr_nrd", rd_log.size() - r0, 3);
        chk("rr_nwr", (a_log.size() - a0) + (b_log.size() - b0), 0);
        q = '{8'h77, 8'h88};
        send_cmd(OP_WRITE_B, 10, 1);
        push_bytes(q);
        chk("rr_post_n", b_log.size() - b0, 2);
        chk("rr_post_a", b_log[b0+1].a, 11);
        chk("rr_post_d", b_log[b0+1].d, 8'h88);
        chk("rr_post_done", xfer_done, 1);
        idle(2);

        // Full 1024-byte transfer wrapping from 512
        q = {};
        for (int i = 0; i < 1024; i++) q.push_back(8'(i * 5 + 1));
        a0 = a_log.size();
        send_cmd(OP_WRITE_A, 512, 1023);
        push_bytes(q);
        chk("full_n", a_log.size() - a0, 1024);
        chk("full_first", a_log[a0].a, 512);
        chk("full_top", a_log[a0+511].a, 1023);
        chk("full_wrap", a_log[a0+512].a, 0);
        chk("full_last", a_log[a0+1023].a, 511);
        chk("full_last_d", a_log[a0+1023].d, q[1023]);
        chk("full_done", xfer_done, 1);
        idle(2);

        chk("nonsel_addr", sel_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/npu_host_xfer.md
Name: npu_host_xfer

Overview:
- Host-side transfer engine for the NPU scratchpads; it is the opposite end of the tile processor's SRAM traffic.
- It writes operand bytes into SRAM A and SRAM B from an inbound byte stream.
- It reads result bytes from SRAM C and returns them on an outbound byte stream with backpressure.
- It sits between the host/DMA interface and the SRAM port muxes. It drives the SRAMs only while the tile processor is idle.

Parameters:
- ADDR_W, 10, SRAM address width (1024 entries)
- DATA_W, 8, SRAM and stream data width
- OBUF_DEPTH, 2, output skid-buffer entries (fixed at 2; sized for 1-cycle SRAM read latency)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  engine idle and able to accept a command
- cmd_op  input  2  0=WRITE_A, 1=WRITE_B, 2=READ_C, 3=reserved
- cmd_base  input  ADDR_W  first SRAM address
- cmd_len_m1  input  ADDR_W  transfer length minus 1 (1..1024 bytes)
- wr_valid  input  1  inbound byte valid
- wr_ready  output  1  inbound byte accepted
- wr_data  input  DATA_W  inbound byte
- rd_valid  output  1  outbound byte valid
- rd_ready  input  1  outbound byte accepted
- rd_data  output  DATA_W  outbound byte
- sram_A_we, sram_B_we  output  1 each  write enables
- sram_A_addr, sram_B_addr, sram_C_addr  output  ADDR_W each  addresses
- sram_A_din, sram_B_din  output  DATA_W each  write data
- sram_C_dout  input  DATA_W  read data, valid 1 cycle after address is presented
- busy  output  1  high in any state other than IDLE
- xfer_done  output  1  one-cycle pulse when a command completes

Behaviour:
- Reset values:
  - All outputs are 0, except cmd_ready=1.
  - State is IDLE, counters are 0, output buffer is empty.
- Reset asserted mid-transfer:
  - Aborts immediately; no further SRAM writes occur.
  - Buffered read bytes are discarded.
- States: IDLE, WRITE, READ, DRAIN.
- Command acceptance:
  - A command is accepted on cmd_valid && cmd_ready.
  - At acceptance: latch op, base and len_m1; set addr=base and remaining=len_m1+1.
  - cmd_ready = (state==IDLE).
- Reserved op 3: the command is accepted and completes as a no-op. xfer_done pulses on the next cycle and no SRAM access occurs.
- WRITE state:
  - wr_ready=1.
  - Each wr_valid&&wr_ready beat drives we=1, addr and din on the selected SRAM in that same cycle, combinationally from the current counters.
  - After each beat, addr increments and remaining decrements.
  - The last beat returns the engine to IDLE and pulses xfer_done in the following cycle.
  - No bubbles: one byte per cycle is sustained.
- READ state:
  - Issue a read (sram_C_addr=addr) when remaining>0 and buffer occupancy + in-flight < 2.
  - One read may be in flight; data is captured into the buffer on the cycle after issue.
  - Once the last read has been issued, move to DRAIN.
- DRAIN state: wait until the in-flight read has landed and the buffer is empty, then go to IDLE and pulse xfer_done.
- Outbound stream:
  - rd_valid = buffer not empty; rd_data = buffer head.
  - rd_data holds stable while rd_valid && !rd_ready.
  - With rd_ready held high, a read transfer of N bytes completes in N+2 cycles after acceptance.
- Address wrap:
  - addr increments modulo 2^ADDR_W, so base 1020 with len 8 touches 1020..1023, 0..3.
  - len_m1=1023 transfers the full 1024 bytes.
- sram_*_we is deasserted in every state except on WRITE beats. Non-selected SRAM addresses hold 0.
- Simultaneous events:
  - In the cycle where the buffer pushes and pops together, occupancy is unchanged.
  - A command presented during busy is not accepted; it is held by the host.

Decomposition:
- Shared package npu_pkg:
  - op enum xfer_op_t: WRITE_A, WRITE_B, READ_C, RSVD
  - state enum xfer_state_t
  - SRAM_ADDR_W=10 and SRAM_DATA_W=8, shared with the tile processor
- One sub-module: npu_skid_fifo, a 2-entry valid/ready FIFO with push/pop/count, used for the read return path.

Test Plan:
- WRITE_A, base 5, len_m1 3, bytes 0x11,0x22,0x33,0x44, wr_valid always high -> sram_A_we high for 4 consecutive cycles at addrs 5,6,7,8; sram_B_we stays 0; xfer_done pulses once.
- WRITE_B, base 1022, len_m1 3 -> writes land at 1022,1023,0,1; busy drops after the 4th beat.
- READ_C, base 0, len_m1 7, SRAM C preloaded with 0xA0..0xA7, rd_ready=1 -> rd_data sequence 0xA0..0xA7 on consecutive cycles; done at acceptance+10.
- READ_C, len_m1 15, rd_ready toggling 1,0,0,1 -> no byte lost or duplicated; rd_data holds while stalled; in-flight never exceeds buffer capacity.
- Command issued while busy -> cmd_ready=0; the second command starts the cycle after xfer_done; back-to-back WRITE_A then READ_C returns the written bytes.
- rst_n pulsed low after 3 of 8 READ_C bytes -> rd_valid=0, cmd_ready=1, all we=0 immediately; a new command then executes normally.
